// File: rtl/frame_refresh_ctrl_if.sv
// frame_refresh_ctrl_if: request, frame-buffer write port and status bundle for the refresh controller
interface frame_refresh_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_start;
  logic             i_abort;
  logic             i_ready;
  logic [8:0]       o_x;
  logic [7:0]       o_y;
  logic             o_we;
  logic             o_busy;
  logic             o_done;
  logic             o_pending;
  logic [CNT_W-1:0] o_frame_cnt;
  modport master (
    input  i_start, i_abort, i_ready,
    output o_x, o_y, o_we, o_busy, o_done, o_pending, o_frame_cnt
  );
  modport slave (
    output i_start, i_abort, i_ready,
    input  o_x, o_y, o_we, o_busy, o_done, o_pending, o_frame_cnt
  );
endinterface

// File: rtl/frame_refresh_ctrl.sv
// frame_refresh_ctrl: sequences full-screen write passes with coalesced requests; FRC_AUTO_REFRESH_EN enables continuous passes
module frame_refresh_ctrl #(
  parameter int H_PIXELS = 400,
  parameter int V_PIXELS = 225,
  parameter int CNT_W    = 16
) (
  input logic i_clk,
  input logic i_rst,
  frame_refresh_ctrl_if.master bus
);
  localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_PIXELS - 1);
`ifdef FRC_AUTO_REFRESH_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic kick;
  // pass sequencer: state, scan address, strobes, pending request and frame counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      kick            <= AUTO;
      bus.o_x         <= '0;
      bus.o_y         <= '0;
      bus.o_we        <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_pending   <= 1'b0;
      bus.o_frame_cnt <= '0;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start || bus.o_pending || kick) begin
            state         <= SCAN;
            kick          <= 1'b0;
            bus.o_we      <= 1'b1;
            bus.o_busy    <= 1'b1;
            bus.o_pending <= 1'b0;
          end
        end
        SCAN: begin
          if (bus.i_abort) begin
            state         <= IDLE;
            bus.o_x       <= '0;
            bus.o_y       <= '0;
            bus.o_we      <= 1'b0;
            bus.o_busy    <= 1'b0;
            bus.o_pending <= 1'b0;
          end else begin
            if (bus.i_start) bus.o_pending <= 1'b1;
            if (bus.o_we && bus.i_ready) begin
              if (bus.o_x < X_LAST) bus.o_x <= bus.o_x + 9'd1;
              else begin
                bus.o_x <= '0;
                if (bus.o_y < Y_LAST) bus.o_y <= bus.o_y + 8'd1;
                else begin
                  state           <= DONE;
                  bus.o_y         <= '0;
                  bus.o_we        <= 1'b0;
                  bus.o_done      <= 1'b1;
                  bus.o_frame_cnt <= bus.o_frame_cnt + 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          bus.o_pending <= 1'b0;
          if (bus.i_abort) begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end else if (AUTO || bus.o_pending || bus.i_start) begin
            state    <= SCAN;
            bus.o_we <= 1'b1;
          end else begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bus.o_we   <= 1'b0;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
